// File: rtl/Thor2022_pkg.sv
// Shared types and helpers for the Thor2022 memory dispatch path.
package Thor2022_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 64;
    localparam int unsigned TAG_W = 8;

    localparam logic [2:0] SZ_BYT   = 3'd0;
    localparam logic [2:0] SZ_WYDE  = 3'd1;
    localparam logic [2:0] SZ_TETRA = 3'd2;
    localparam logic [2:0] SZ_OCTA  = 3'd3;

    typedef enum logic [3:0] {
        MR_NOP   = 4'd0,
        MR_LOAD  = 4'd1,
        MR_LOADZ = 4'd2,
        MR_STORE = 4'd3
    } MemoryFunc;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        MemoryFunc        func;
        logic [2:0]       sz;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } MemoryRequest;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } MemDispatchState;

    // Byte-lane select for an access size, lane 0 aligned; unknown sizes act as octa.
    function automatic logic [7:0] fnSel(input logic [2:0] sz);
        case (sz)
            SZ_BYT:   return 8'h01;
            SZ_WYDE:  return 8'h03;
            SZ_TETRA: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/thor2022_load_align.sv
// Aligns, masks and extends load data from a two-beat read window.
module thor2022_load_align
    import Thor2022_pkg::*;
(
    input  logic [255:0] rd,
    input  logic [3:0]   off,
    input  logic [2:0]   sz,
    input  MemoryFunc    func,
    input  logic [63:0]  dat_in,
    output logic [63:0]  dat_c
);

    logic [63:0] raw;
    logic [63:0] mask;
    logic [7:0]  sel;
    logic        sign;

    assign raw = 64'(rd >> {off, 3'b000});
    assign sel = fnSel(sz);

    // Expand lane selects to a bit mask and pick the top data bit of the access.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        case (sz)
            SZ_BYT:   sign = raw[7];
            SZ_WYDE:  sign = raw[15];
            SZ_TETRA: sign = raw[31];
            default:  sign = raw[63];
        endcase
    end

    // Sign-extend, zero-extend, or pass the request data through.
    always_comb begin
        case (func)
            MR_LOAD:  dat_c = (raw & mask) | ({64{sign}} & ~mask);
            MR_LOADZ: dat_c = raw & mask;
            default:  dat_c = dat_in;
        endcase
    end

endmodule

// File: rtl/thor2022_mem_dispatch.sv
// Pops memory requests and runs them as one or two aligned 16-byte bus beats.
module thor2022_mem_dispatch
    import Thor2022_pkg::*;
#(
    parameter int unsigned AWID = 32,
    parameter int unsigned TMO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_valid,
    input  MemoryRequest      q_req,
    output logic              q_rd,
    output logic              breq,
    input  logic              back,
    input  logic              berr,
    output logic              bwe,
    output logic [AWID-1:0]   badr,
    output logic [15:0]       bsel,
    output logic [127:0]      bdat_o,
    input  logic [127:0]      bdat_i,
    output logic              resp_valid,
    output MemoryRequest      resp,
    output logic              resp_err,
    input  logic              resp_ack
);

    MemDispatchState state_q, state_d;
    MemoryRequest    req_q, req_d, resp_q, resp_d;
    logic            q_rd_q, q_rd_d, breq_q, breq_d, bwe_q, bwe_d;
    logic            resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [AWID-1:0] badr_q, badr_d;
    logic [15:0]     bsel_q, bsel_d;
    logic [127:0]    bdat_q, bdat_d;
    logic [127:0]    rd0_q, rd0_d, rd1_q, rd1_d;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic [31:0]     sel32;
    logic [255:0]    wdat;
    logic [63:0]     load_dat_c;
    logic            split;
    logic            done;

    assign sel32   = 32'(fnSel(req_q.sz)) << req_q.adr[3:0];
    assign split   = |sel32[31:16];
    assign wdat    = 256'(req_q.dat) << {req_q.adr[3:0], 3'b000};
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Capture read data on the completing edge of each beat.
    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (breq_q && back) begin
            if (state_q == BEAT0) rd0_d = bdat_i;
            else if (state_q == BEAT1) rd1_d = bdat_i;
        end
    end

    thor2022_load_align u_align (
        .rd     ({rd1_d, rd0_d}),
        .off    (req_q.adr[3:0]),
        .sz     (req_q.sz),
        .func   (req_q.func),
        .dat_in (req_q.dat),
        .dat_c  (load_dat_c)
    );

    // Next-state and output logic for pop, beats, timeout and response.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        q_rd_d       = 1'b0;
        breq_d       = breq_q;
        bwe_d        = bwe_q;
        badr_d       = badr_q;
        bsel_d       = bsel_q;
        bdat_d       = bdat_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    q_rd_d  = 1'b1;
                    req_d   = q_req;
                    cnt_d   = '0;
                    state_d = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                if (!breq_q) begin
                    breq_d = 1'b1;
                    bwe_d  = (req_q.func == MR_STORE);
                    badr_d = {req_q.adr[AWID-1:4], 4'h0};
                    bsel_d = sel32[15:0];
                    bdat_d = wdat[127:0];
                end else if (back) begin
                    if (berr) begin
                        resp_err_d = 1'b1;
                        done       = 1'b1;
                    end else if (state_q == BEAT0 && split) begin
                        state_d = BEAT1;
                        badr_d  = badr_q + AWID'(16);
                        bsel_d  = sel32[31:16];
                        bdat_d  = wdat[255:128];
                        cnt_d   = '0;
                    end else begin
                        resp_err_d = 1'b0;
                        done       = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= 8'(TMO)) begin
                        resp_err_d = 1'b1;
                        done       = 1'b1;
                    end
                end
                if (done) begin
                    state_d      = RESP;
                    breq_d       = 1'b0;
                    bwe_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_d       = req_q;
                    resp_d.dat   = load_dat_c;
                end
            end
            RESP: begin
                if (resp_ack) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            q_rd_q       <= 1'b0;
            breq_q       <= 1'b0;
            bwe_q        <= 1'b0;
            badr_q       <= '0;
            bsel_q       <= '0;
            bdat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            q_rd_q       <= q_rd_d;
            breq_q       <= breq_d;
            bwe_q        <= bwe_d;
            badr_q       <= badr_d;
            bsel_q       <= bsel_d;
            bdat_q       <= bdat_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign q_rd       = q_rd_q;
    assign breq       = breq_q;
    assign bwe        = bwe_q;
    assign badr       = badr_q;
    assign bsel       = bsel_q;
    assign bdat_o     = bdat_q;
    assign resp_valid = resp_valid_q;
    assign resp       = resp_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_thor2022_mem_dispatch.sv
// Directed and randomized bench for thor2022_mem_dispatch against a byte-lane model.
module tb_thor2022_mem_dispatch;
    import Thor2022_pkg::*;

    logic         clk = 1'b0;
    logic         rst, q_valid, q_rd, breq, back, berr, bwe;
    logic         resp_valid, resp_err, resp_ack;
    MemoryRequest q_req, resp;
    logic [31:0]  badr;
    logic [15:0]  bsel;
    logic [127:0] bdat_o, bdat_i;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    thor2022_mem_dispatch #(.AWID(32), .TMO(4)) dut (
        .clk(clk), .rst(rst), .q_valid(q_valid), .q_req(q_req), .q_rd(q_rd),
        .breq(breq), .back(back), .berr(berr), .bwe(bwe), .badr(badr),
        .bsel(bsel), .bdat_o(bdat_o), .bdat_i(bdat_i), .resp_valid(resp_valid),
        .resp(resp), .resp_err(resp_err), .resp_ack(resp_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare an observed value against its expectation and count the result.
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full request: pop, serve beats from the model, check response, ack.
    task automatic do_req(input MemoryRequest r, input logic [127:0] rd0_in, input logic [127:0] rd1_in,
                          input int back_dly, input int err_beat, input bit tmo, input int ack_dly,
                          output logic [63:0] got_dat);
        logic [7:0]   wb[32];
        logic [7:0]   rb[32];
        logic [127:0] rdat[2];
        logic [31:0]  lane, ba;
        logic [127:0] eb;
        logic [63:0]  ev;
        int off, n, nb, t0, t;
        bit ok, err_exp, sgn;
        off = int'(r.adr[3:0]);
        n = nbytes(r.sz);
        nb = (off + n > 16) ? 2 : 1;
        lane = '0;
        for (int i = 0; i < n; i++) lane[off+i] = 1'b1;
        for (int i = 0; i < 32; i++) wb[i] = 8'h00;
        for (int i = 0; i < 8; i++) wb[off+i] = r.dat[8*i +: 8];
        rdat[0] = rd0_in;
        rdat[1] = rd1_in;
        for (int i = 0; i < 16; i++) begin
            rb[i]    = rd0_in[8*i +: 8];
            rb[16+i] = rd1_in[8*i +: 8];
        end
        q_req = r;
        q_valid = 1'b1;
        ok = 0;
        for (t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (q_rd) begin ok = 1; break; end
        end
        chk("pop", ok, 1'b1);
        q_valid = 1'b0;
        t0 = cyc;
        chk("breq_after_pop", breq, 1'b0);
        back = 1'($urandom_range(0, 1));
        err_exp = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == 0) begin
                ok = 0;
                for (t = 0; t < 5; t++) begin
                    @(posedge clk); #1;
                    back = 1'b0;
                    if (breq) begin ok = 1; break; end
                end
                chk("breq_rise", ok, 1'b1);
                chk("breq_rise_cycle", cyc - t0, 1);
            end else begin
                chk("breq_cont", breq, 1'b1);
            end
            ba = {r.adr[31:4], 4'h0} + ((b == 1) ? 32'd16 : 32'd0);
            for (int i = 0; i < 16; i++) eb[8*i +: 8] = wb[16*b+i];
            chk("badr", badr, ba);
            chk("bsel", bsel, lane[16*b +: 16]);
            chk("bwe", bwe, (r.func == MR_STORE));
            chk("bdat_o", bdat_o, eb);
            if (tmo) begin
                t = 0;
                while (breq && t < 20) begin
                    @(posedge clk); #1;
                    t++;
                end
                chk("tmo_cycles", t, 4);
                err_exp = 1;
                break;
            end
            repeat (back_dly) begin @(posedge clk); #1; end
            chk("badr_stable", badr, ba);
            chk("bsel_stable", bsel, lane[16*b +: 16]);
            back = 1'b1;
            bdat_i = rdat[b];
            berr = (err_beat == b);
            @(posedge clk); #1;
            back = 1'b0;
            berr = 1'b0;
            if (err_beat == b) begin err_exp = 1; break; end
        end
        chk("resp_valid", resp_valid, 1'b1);
        chk("breq_fall", breq, 1'b0);
        chk("resp_err", resp_err, err_exp);
        chk("resp_tag", resp.tag, r.tag);
        chk("resp_adr", resp.adr, r.adr);
        chk("resp_func", resp.func, r.func);
        if (!err_exp) begin
            if (r.func == MR_LOAD || r.func == MR_LOADZ) begin
                sgn = (r.func == MR_LOAD) && rb[off+n-1][7];
                for (int i = 0; i < 8; i++)
                    ev[8*i +: 8] = (i < n) ? rb[off+i] : (sgn ? 8'hFF : 8'h00);
            end else begin
                ev = r.dat;
            end
            chk("resp_dat", resp.dat, ev);
            if (back_dly == 0) chk("latency", cyc - t0, nb + 1);
        end
        got_dat = resp.dat;
        q_valid = (ack_dly > 0);
        repeat (ack_dly) begin
            @(posedge clk); #1;
            chk("resp_hold", resp_valid, 1'b1);
            chk("no_pop_in_resp", q_rd, 1'b0);
        end
        resp_ack = 1'b1;
        @(posedge clk); #1;
        resp_ack = 1'b0;
        q_valid = 1'b0;
        chk("resp_drop", resp_valid, 1'b0);
        chk("no_pop_on_ack", q_rd, 1'b0);
    endtask

    initial begin
        MemoryRequest r;
        logic [63:0]  got;
        bit ok;
        rst = 1'b1; q_valid = 1'b0; q_req = '0; back = 1'b0; berr = 1'b0;
        bdat_i = '0; resp_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_rd", q_rd, 1'b0);
        chk("rst_breq", breq, 1'b0);
        chk("rst_bwe", bwe, 1'b0);
        chk("rst_badr", badr, 32'h0);
        chk("rst_bsel", bsel, 16'h0);
        chk("rst_bdat", bdat_o, 128'h0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp", resp, MemoryRequest'(0));
        rst = 1'b0;

        // Tetra load at 0x104, sign-extended.
        r = '{tag: 8'h11, func: MR_LOAD, sz: SZ_TETRA, adr: 32'h104, dat: 64'h0};
        do_req(r, 128'h0000_0000_0000_0000_8000_0000_DEAD_BEEF, 128'h0, 0, -1, 0, 0, got);
        chk("tetra_sext", got, 64'hFFFF_FFFF_8000_0000);

        // Octa store straddling 0x110.
        r = '{tag: 8'h22, func: MR_STORE, sz: SZ_OCTA, adr: 32'h10C, dat: 64'h1122334455667788};
        do_req(r, rand128(), rand128(), 0, -1, 0, 0, got);

        // Wyde zero-extended load wrapping the address space.
        r = '{tag: 8'h33, func: MR_LOADZ, sz: SZ_WYDE, adr: 32'hFFFF_FFFF, dat: 64'h0};
        do_req(r, 128'hAB00_0000_0000_0000_0000_0000_0000_0000, 128'h0000_0000_0000_0000_0000_0000_0000_00CD,
               1, -1, 0, 0, got);
        chk("wyde_zext", got, 64'h0000_0000_0000_CDAB);

        // Bus timeout.
        r = '{tag: 8'h44, func: MR_LOAD, sz: SZ_BYT, adr: 32'h200, dat: 64'h0};
        do_req(r, rand128(), rand128(), 0, -1, 1, 0, got);

        // Split load with error on first beat, slow ack.
        r = '{tag: 8'h55, func: MR_LOAD, sz: SZ_OCTA, adr: 32'h30A, dat: 64'h0};
        do_req(r, rand128(), rand128(), 0, 0, 0, 5, got);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            r.tag  = 8'($urandom);
            r.func = MemoryFunc'(4'($urandom_range(0, 3)));
            r.sz   = 3'($urandom_range(0, 4));
            r.adr  = $urandom;
            r.dat  = {$urandom, $urandom};
            do_req(r, rand128(), rand128(), $urandom_range(0, 2),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1,
                   0, $urandom_range(0, 2), got);
        end

        // Reset during the second beat.
        r = '{tag: 8'h66, func: MR_LOAD, sz: SZ_OCTA, adr: 32'h2C, dat: 64'h0};
        q_req = r;
        q_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (q_rd) begin ok = 1; break; end
        end
        chk("rst_test_pop", ok, 1'b1);
        q_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (breq) begin ok = 1; break; end
        end
        chk("rst_test_breq", ok, 1'b1);
        back = 1'b1;
        bdat_i = rand128();
        @(posedge clk); #1;
        back = 1'b0;
        chk("rst_test_beat1", breq, 1'b1);
        chk("rst_test_badr1", badr, 32'h30);
        rst = 1'b1;
        q_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_breq", breq, 1'b0);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_q_rd", q_rd, 1'b0);
        @(posedge clk); #1;
        chk("midrst_q_rd2", q_rd, 1'b0);
        rst = 1'b0;
        r = '{tag: 8'h77, func: MR_LOADZ, sz: SZ_BYT, adr: 32'h47, dat: 64'h0};
        do_req(r, 128'h0000_0000_0000_0000_9A00_0000_0000_0000, rand128(), 0, -1, 0, 0, got);
        chk("post_rst_byte", got, 64'h9A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
